// File: rtl/i2c_txn_sequencer.sv
// Byte-level I2C master transaction sequencer: turns one start request into START/WRITE/READ/STOP engine commands.
// Optional 10-bit addressing is compiled in with `define TEN_BIT_ADDR_EN.
module i2c_txn_sequencer #(
  parameter int CNT_W = 5
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             start_req,
  input  logic             rw,
  input  logic             ten_bit,
  input  logic [9:0]       addr,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [7:0]       tx_data,
  input  logic             tx_empty,
  output logic             tx_r_ena,
  input  logic             rx_full,
  output logic [7:0]       rx_data,
  output logic             rx_w_ena,
  output logic             cmd_valid,
  output logic [1:0]       cmd,
  output logic [7:0]       cmd_data,
  output logic             cmd_nack,
  input  logic             cmd_ready,
  input  logic             rsp_valid,
  input  logic [7:0]       rsp_data,
  input  logic             rsp_nack,
  input  logic             arb_lost,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             arb_err,
  output logic             txn_begin,
  output logic             txn_abort
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_HDR, S_ALO, S_RSTART, S_HDR_R, S_WR, S_RD, S_STOP
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  state_t           state_r, state_nxt_s, target_s;
  logic             cmd_valid_r, cmd_valid_nxt_s;
  logic [1:0]       cmd_r, cmd_nxt_s;
  logic [7:0]       cmd_data_r, cmd_data_nxt_s;
  logic             cmd_nack_r, cmd_nack_nxt_s;
  logic             rsp_wait_r, rsp_wait_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             nack_err_r, nack_err_nxt_s;
  logic             arb_err_r, arb_err_nxt_s;
  logic             txn_begin_r, txn_begin_nxt_s;
  logic             txn_abort_r, txn_abort_nxt_s;
  logic             rw_r, rw_nxt_s;
  logic             ten_r, ten_nxt_s;
  logic [9:0]       addr_r, addr_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             nack_seen_r, nack_seen_nxt_s;
  logic             issue_s;
  logic             tx_r_ena_s, rx_w_ena_s;

  // Next-state, command issue and pulse generation
  always_comb begin
    state_nxt_s     = state_r;
    target_s        = state_r;
    cmd_valid_nxt_s = cmd_valid_r;
    cmd_nxt_s       = cmd_r;
    cmd_data_nxt_s  = cmd_data_r;
    cmd_nack_nxt_s  = cmd_nack_r;
    rsp_wait_nxt_s  = rsp_wait_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
    nack_err_nxt_s  = 1'b0;
    arb_err_nxt_s   = 1'b0;
    txn_begin_nxt_s = 1'b0;
    txn_abort_nxt_s = 1'b0;
    rw_nxt_s        = rw_r;
    ten_nxt_s       = ten_r;
    addr_nxt_s      = addr_r;
    cnt_nxt_s       = cnt_r;
    nack_seen_nxt_s = nack_seen_r;
    issue_s         = 1'b0;
    tx_r_ena_s      = 1'b0;
    rx_w_ena_s      = 1'b0;

    if (state_r == S_IDLE) begin
      if (start_req) begin
        rw_nxt_s        = rw;
`ifdef TEN_BIT_ADDR_EN
        ten_nxt_s       = ten_bit;
`else
        ten_nxt_s       = ten_bit & 1'b0;
`endif
        addr_nxt_s      = addr;
        cnt_nxt_s       = byte_count;
        nack_seen_nxt_s = 1'b0;
        txn_begin_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
        target_s        = S_START;
        issue_s         = 1'b1;
      end else begin
        issue_s = 1'b0;
      end
    end else if (arb_lost) begin
      // Bus is gone: abandon without a STOP
      state_nxt_s     = S_IDLE;
      cmd_valid_nxt_s = 1'b0;
      rsp_wait_nxt_s  = 1'b0;
      busy_nxt_s      = 1'b0;
      nack_seen_nxt_s = 1'b0;
      arb_err_nxt_s   = 1'b1;
      txn_abort_nxt_s = 1'b1;
    end else if (cmd_valid_r) begin
      if (cmd_ready) begin
        cmd_valid_nxt_s = 1'b0;
        rsp_wait_nxt_s  = 1'b1;
        tx_r_ena_s      = (state_r == S_WR);
      end else begin
        cmd_valid_nxt_s = 1'b1;
      end
    end else if (rsp_wait_r) begin
      if (rsp_valid) begin
        rsp_wait_nxt_s = 1'b0;
        issue_s        = 1'b1;
        case (state_r)
          S_START:  target_s = S_HDR;
          S_RSTART: target_s = S_HDR_R;
          S_HDR: begin
            if (rsp_nack) begin
              target_s        = S_STOP;
              nack_seen_nxt_s = 1'b1;
            end else if (ten_r) begin
              target_s = S_ALO;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
              target_s = S_STOP;
            end else begin
              target_s = rw_r ? S_RD : S_WR;
            end
          end
          S_ALO: begin
            if (rsp_nack) begin
              target_s        = S_STOP;
              nack_seen_nxt_s = 1'b1;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
              target_s = S_STOP;
            end else begin
              target_s = rw_r ? S_RSTART : S_WR;
            end
          end
          S_HDR_R: begin
            if (rsp_nack) begin
              target_s        = S_STOP;
              nack_seen_nxt_s = 1'b1;
            end else begin
              target_s = (cnt_r == {CNT_W{1'b0}}) ? S_STOP : S_RD;
            end
          end
          S_WR: begin
            if (rsp_nack) begin
              target_s        = S_STOP;
              nack_seen_nxt_s = 1'b1;
            end else begin
              cnt_nxt_s = cnt_r - CNT_W'(1);
              target_s  = (cnt_r == CNT_W'(1)) ? S_STOP : S_WR;
            end
          end
          S_RD: begin
            rx_w_ena_s = 1'b1;
            cnt_nxt_s  = cnt_r - CNT_W'(1);
            target_s   = (cnt_r == CNT_W'(1)) ? S_STOP : S_RD;
          end
          S_STOP: begin
            target_s        = S_IDLE;
            busy_nxt_s      = 1'b0;
            nack_seen_nxt_s = 1'b0;
            done_nxt_s      = ~nack_seen_r;
            nack_err_nxt_s  = nack_seen_r;
            txn_abort_nxt_s = nack_seen_r;
          end
          default: begin
            target_s   = S_IDLE;
            busy_nxt_s = 1'b0;
          end
        endcase
      end else begin
        rsp_wait_nxt_s = 1'b1;
      end
    end else begin
      // Stalled before issue (FIFO empty/full): retry the current state's command
      issue_s = 1'b1;
    end

    if (issue_s) begin
      state_nxt_s     = target_s;
      cmd_valid_nxt_s = 1'b1;
      cmd_data_nxt_s  = 8'h00;
      cmd_nack_nxt_s  = 1'b0;
      case (target_s)
        S_START, S_RSTART: cmd_nxt_s = CMD_START;
        S_HDR: begin
          cmd_nxt_s      = CMD_WRITE;
          cmd_data_nxt_s = ten_nxt_s ? {5'b11110, addr_nxt_s[9:8], 1'b0} : {addr_nxt_s[6:0], rw_nxt_s};
        end
        S_ALO: begin
          cmd_nxt_s      = CMD_WRITE;
          cmd_data_nxt_s = addr_nxt_s[7:0];
        end
        S_HDR_R: begin
          cmd_nxt_s      = CMD_WRITE;
          cmd_data_nxt_s = {5'b11110, addr_nxt_s[9:8], 1'b1};
        end
        S_WR: begin
          cmd_nxt_s       = CMD_WRITE;
          cmd_valid_nxt_s = ~tx_empty;
          cmd_data_nxt_s  = tx_data;
        end
        S_RD: begin
          cmd_nxt_s       = CMD_READ;
          cmd_valid_nxt_s = ~rx_full;
          cmd_nack_nxt_s  = (cnt_nxt_s == CNT_W'(1));
        end
        S_STOP: cmd_nxt_s = CMD_STOP;
        default: begin
          cmd_nxt_s       = CMD_START;
          cmd_valid_nxt_s = 1'b0;
        end
      endcase
    end else begin
      issue_s = 1'b0;
    end
  end

  // State and registered-output update
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cmd_valid_r <= 1'b0;
      cmd_r       <= 2'b00;
      cmd_data_r  <= 8'h00;
      cmd_nack_r  <= 1'b0;
      rsp_wait_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      nack_err_r  <= 1'b0;
      arb_err_r   <= 1'b0;
      txn_begin_r <= 1'b0;
      txn_abort_r <= 1'b0;
      rw_r        <= 1'b0;
      ten_r       <= 1'b0;
      addr_r      <= 10'h000;
      cnt_r       <= {CNT_W{1'b0}};
      nack_seen_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_valid_r <= cmd_valid_nxt_s;
      cmd_r       <= cmd_nxt_s;
      cmd_data_r  <= cmd_data_nxt_s;
      cmd_nack_r  <= cmd_nack_nxt_s;
      rsp_wait_r  <= rsp_wait_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      nack_err_r  <= nack_err_nxt_s;
      arb_err_r   <= arb_err_nxt_s;
      txn_begin_r <= txn_begin_nxt_s;
      txn_abort_r <= txn_abort_nxt_s;
      rw_r        <= rw_nxt_s;
      ten_r       <= ten_nxt_s;
      addr_r      <= addr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      nack_seen_r <= nack_seen_nxt_s;
    end
  end

  // FIFO strobes must land in the accept/response cycle itself
  assign tx_r_ena  = tx_r_ena_s;
  assign rx_w_ena  = rx_w_ena_s;
  assign rx_data   = rx_w_ena_s ? rsp_data : 8'h00;
  assign cmd_valid = cmd_valid_r;
  assign cmd       = cmd_r;
  assign cmd_data  = cmd_data_r;
  assign cmd_nack  = cmd_nack_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign nack_err  = nack_err_r;
  assign arb_err   = arb_err_r;
  assign txn_begin = txn_begin_r;
  assign txn_abort = txn_abort_r;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed self-checking bench for i2c_txn_sequencer; define TEN_BIT_ADDR_EN to add the 10-bit read scenario.
module tb_i2c_txn_sequencer;
  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       start_req = 1'b0, rw = 1'b0, ten_bit = 1'b0;
  logic [9:0] addr = 10'h000;
  logic [4:0] byte_count = 5'd0;
  logic [7:0] tx_data;
  logic       tx_empty, tx_r_ena, rx_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_w_ena, cmd_valid;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_nack, cmd_ready = 1'b0, rsp_valid = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       rsp_nack = 1'b0, arb_lost = 1'b0;
  logic       busy, done, nack_err, arb_err, txn_begin, txn_abort;

  localparam logic [1:0] C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11;

  int checks = 0, errors = 0;
  logic [7:0] tx_mem [0:63];
  int tx_head = 0, tx_limit = 0;
  logic force_empty = 1'b0;
  logic [7:0] rx_log [0:63];
  int n_pop = 0, n_push = 0, n_done = 0, n_nack = 0, n_arb = 0, n_begin = 0, n_abort = 0;

  assign tx_data  = tx_mem[tx_head[5:0]];
  assign tx_empty = force_empty || (tx_head >= tx_limit);

  i2c_txn_sequencer #(.CNT_W(5)) dut (
    .pclk(pclk), .rst(rst), .start_req(start_req), .rw(rw), .ten_bit(ten_bit), .addr(addr),
    .byte_count(byte_count), .tx_data(tx_data), .tx_empty(tx_empty), .tx_r_ena(tx_r_ena),
    .rx_full(rx_full), .rx_data(rx_data), .rx_w_ena(rx_w_ena), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_nack(rsp_nack), .arb_lost(arb_lost), .busy(busy), .done(done),
    .nack_err(nack_err), .arb_err(arb_err), .txn_begin(txn_begin), .txn_abort(txn_abort)
  );

  always #5 pclk = ~pclk;

  // FIFO model and pulse counters, sampled mid-cycle
  always @(negedge pclk) begin
    if (tx_r_ena) begin n_pop++; tx_head++; end
    if (rx_w_ena) begin rx_log[n_push[5:0]] = rx_data; n_push++; end
    if (done) n_done++;
    if (nack_err) n_nack++;
    if (arb_err) n_arb++;
    if (txn_begin) n_begin++;
    if (txn_abort) n_abort++;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_limit[5:0]] = b;
    tx_limit++;
  endtask

  task automatic start_txn(input logic r, input logic tb_, input logic [9:0] a, input logic [4:0] c);
    rw = r; ten_bit = tb_; addr = a; byte_count = c; start_req = 1'b1;
    tick();
    start_req = 1'b0; rw = 1'b0; ten_bit = 1'b0; addr = 10'h000; byte_count = 5'd0;
  endtask

  // Engine model: waits for a command, checks it, accepts it, then responds one idle cycle later
  task automatic eng(input string nm, input logic [1:0] ec, input logic [7:0] ed, input logic en,
                     input logic [7:0] rd, input logic nk);
    int n = 0;
    logic [10:0] obs, exp;
    while (cmd_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: cmd_valid=%b want 1", nm, cmd_valid);
    end else begin
      obs = {cmd, (ec == C_WRITE) ? cmd_data : 8'h00, (ec == C_READ) ? cmd_nack : 1'b0};
      exp = {ec, (ec == C_WRITE) ? ed : 8'h00, (ec == C_READ) ? en : 1'b0};
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s: got cmd/data/nack %h want %h", nm, obs, exp);
      end
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      tick();
      rsp_valid = 1'b1; rsp_data = rd; rsp_nack = nk; tick();
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    end
  endtask

  function automatic logic [27:0] all_outs();
    return {tx_r_ena, rx_data, rx_w_ena, cmd_valid, cmd, cmd_data, cmd_nack,
            busy, done, nack_err, arb_err, txn_begin, txn_abort};
  endfunction

  task automatic test_reset();
    rsp_data = 8'hFF;
    tick(); tick();
    checks++;
    if (all_outs() !== 28'h0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    rsp_data = 8'h00; rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int p0 = n_pop, d0 = n_done, b0 = n_begin;
    push_tx(8'hA5); push_tx(8'h3C);
    start_txn(1'b0, 1'b0, 10'h050, 5'd2);
    checks++;
    if ({busy, txn_begin, cmd_valid} !== 3'b111) begin
      errors++; $display("FAIL wr_begin: busy/begin/valid=%b want 111", {busy, txn_begin, cmd_valid});
    end
    eng("wr_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("wr_hdr", C_WRITE, 8'hA0, 1'b0, 8'h00, 1'b0);
    eng("wr_d0", C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0);
    eng("wr_d1", C_WRITE, 8'h3C, 1'b0, 8'h00, 1'b0);
    eng("wr_stop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL wr_done: done/busy=%b want 10", {done, busy}); end
    tick();
    checks++;
    if (n_pop - p0 != 2 || n_done - d0 != 1 || n_begin - b0 != 1) begin
      errors++; $display("FAIL wr_counts: pops %0d done %0d begin %0d want 2 1 1", n_pop - p0, n_done - d0, n_begin - b0);
    end
  endtask

  task automatic test_read();
    int r0 = n_push, d0 = n_done;
    start_txn(1'b1, 1'b0, 10'h050, 5'd3);
    eng("rd_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("rd_hdr", C_WRITE, 8'hA1, 1'b0, 8'h00, 1'b0);
    eng("rd_b0", C_READ, 8'h00, 1'b0, 8'h11, 1'b0);
    eng("rd_b1", C_READ, 8'h00, 1'b0, 8'h22, 1'b0);
    eng("rd_b2", C_READ, 8'h00, 1'b1, 8'h33, 1'b0);
    eng("rd_stop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (n_push - r0 != 3 || n_done - d0 != 1) begin
      errors++; $display("FAIL rd_counts: pushes %0d done %0d want 3 1", n_push - r0, n_done - d0);
    end
    checks++;
    if ({rx_log[r0], rx_log[r0+1], rx_log[r0+2]} !== 24'h112233) begin
      errors++; $display("FAIL rd_data: got %h want 112233", {rx_log[r0], rx_log[r0+1], rx_log[r0+2]});
    end
  endtask

  task automatic test_addr_nack();
    int p0 = n_pop, d0 = n_done, k0 = n_nack, a0 = n_abort;
    start_txn(1'b0, 1'b0, 10'h050, 5'd2);
    eng("nk_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("nk_hdr", C_WRITE, 8'hA0, 1'b0, 8'h00, 1'b1);
    eng("nk_stop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({nack_err, txn_abort, done, busy} !== 4'b1100) begin
      errors++; $display("FAIL nk_pulse: nack/abort/done/busy=%b want 1100", {nack_err, txn_abort, done, busy});
    end
    tick();
    checks++;
    if (n_pop != p0 || n_done != d0 || n_nack - k0 != 1 || n_abort - a0 != 1) begin
      errors++; $display("FAIL nk_counts: pops %0d done %0d nack %0d abort %0d want 0 0 1 1",
                         n_pop - p0, n_done - d0, n_nack - k0, n_abort - a0);
    end
  endtask

  task automatic test_probe();
    int d0 = n_done;
`ifdef TEN_BIT_ADDR_EN
    logic tsel = 1'b0;
`else
    logic tsel = 1'b1;
`endif
    start_txn(1'b0, tsel, 10'h2A5, 5'd0);
    eng("pr_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("pr_hdr", C_WRITE, 8'h4A, 1'b0, 8'h00, 1'b0);
    eng("pr_stop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL pr_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_backpressure();
    int bad = 0, p0, r0, d0 = n_done;
    push_tx(8'h5A);
    start_txn(1'b0, 1'b0, 10'h050, 5'd1);
    eng("bp_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid !== 1'b1 || cmd !== C_WRITE || cmd_data !== 8'hA0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_ready_hold: unstable cycles %0d want 0", bad); end
    force_empty = 1'b1;
    eng("bp_hdr", C_WRITE, 8'hA0, 1'b0, 8'h00, 1'b0);
    p0 = n_pop; bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || n_pop != p0) begin errors++; $display("FAIL bp_tx_empty: valid cycles %0d pops %0d want 0 0", bad, n_pop - p0); end
    force_empty = 1'b0;
    eng("bp_wr", C_WRITE, 8'h5A, 1'b0, 8'h00, 1'b0);
    eng("bp_stop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    rx_full = 1'b1;
    start_txn(1'b1, 1'b0, 10'h050, 5'd1);
    eng("bp_rstart", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("bp_rhdr", C_WRITE, 8'hA1, 1'b0, 8'h00, 1'b0);
    r0 = n_push; bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || n_push != r0) begin errors++; $display("FAIL bp_rx_full: valid cycles %0d pushes %0d want 0 0", bad, n_push - r0); end
    rx_full = 1'b0;
    eng("bp_rd", C_READ, 8'h00, 1'b1, 8'h77, 1'b0);
    eng("bp_rstop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (n_push - r0 != 1 || rx_log[r0] !== 8'h77 || n_done - d0 != 2) begin
      errors++; $display("FAIL bp_end: pushes %0d data %h done %0d want 1 77 2", n_push - r0, rx_log[r0], n_done - d0);
    end
  endtask

  task automatic test_arb_lost();
    int p0 = n_pop, b0 = n_begin, g0 = n_arb, a0 = n_abort, d0 = n_done, bad = 0;
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    start_txn(1'b0, 1'b0, 10'h050, 5'd3);
    eng("arb_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    rw = 1'b1; addr = 10'h011; byte_count = 5'd4; start_req = 1'b1; tick(); start_req = 1'b0;
    eng("arb_hdr", C_WRITE, 8'hA0, 1'b0, 8'h00, 1'b0);
    eng("arb_d0", C_WRITE, 8'h01, 1'b0, 8'h00, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h02) begin
      errors++; $display("FAIL arb_d1_issue: valid/data %b/%h want 1/02", cmd_valid, cmd_data);
    end
    arb_lost = 1'b1; tick(); arb_lost = 1'b0;
    checks++;
    if ({busy, arb_err, txn_abort, cmd_valid, done} !== 5'b01100) begin
      errors++; $display("FAIL arb_pulse: busy/arb/abort/valid/done=%b want 01100", {busy, arb_err, txn_abort, cmd_valid, done});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || n_pop - p0 != 1 || n_begin - b0 != 1 || n_arb - g0 != 1 || n_abort - a0 != 1 || n_done != d0) begin
      errors++; $display("FAIL arb_counts: valid %0d pops %0d begin %0d arb %0d abort %0d done %0d want 0 1 1 1 1 0",
                         bad, n_pop - p0, n_begin - b0, n_arb - g0, n_abort - a0, n_done - d0);
    end
  endtask

`ifdef TEN_BIT_ADDR_EN
  task automatic test_ten_bit();
    int r0 = n_push, d0 = n_done;
    start_txn(1'b1, 1'b1, 10'h2A5, 5'd1);
    eng("tb_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("tb_hdr", C_WRITE, 8'hF4, 1'b0, 8'h00, 1'b0);
    eng("tb_alo", C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0);
    eng("tb_rstart", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("tb_hdr_r", C_WRITE, 8'hF5, 1'b0, 8'h00, 1'b0);
    eng("tb_rd", C_READ, 8'h00, 1'b1, 8'h99, 1'b0);
    eng("tb_stop", C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (n_push - r0 != 1 || rx_log[r0] !== 8'h99 || n_done - d0 != 1) begin
      errors++; $display("FAIL tb_end: pushes %0d data %h done %0d want 1 99 1", n_push - r0, rx_log[r0], n_done - d0);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n = 0, r0, d0 = n_done, k0 = n_nack, g0 = n_arb, a0 = n_abort;
    start_txn(1'b1, 1'b0, 10'h050, 5'd2);
    eng("rm_start", C_START, 8'h00, 1'b0, 8'h00, 1'b0);
    eng("rm_hdr", C_WRITE, 8'hA1, 1'b0, 8'h00, 1'b0);
    while (cmd_valid !== 1'b1 && n < 20) begin tick(); n++; end
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    r0 = n_push;
    rsp_valid = 1'b1; rsp_data = 8'h55; rst = 1'b1; #1;
    checks++;
    if (all_outs() !== 28'h0) begin errors++; $display("FAIL rm_in_reset: got %h want 0", all_outs()); end
    tick(); rsp_valid = 1'b0; rsp_data = 8'h00; rst = 1'b0;
    tick(); tick();
    checks++;
    if (all_outs() !== 28'h0 || n_push != r0 || n_done != d0 || n_nack != k0 || n_arb != g0 || n_abort != a0) begin
      errors++; $display("FAIL rm_after: outs %h pushes %0d pulses %0d want 0 0 0", all_outs(), n_push - r0,
                         (n_done - d0) + (n_nack - k0) + (n_arb - g0) + (n_abort - a0));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_probe();
    test_backpressure();
    test_arb_lost();
`ifdef TEN_BIT_ADDR_EN
    test_ten_bit();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
